// File: rtl/controle_minimo_10bit.sv
// Block-minimum finder: streams N_AMOSTRAS unsigned 10-bit samples through one
// shared menor_10bit comparator and offers minimum plus its position to a consumer.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// OCIOSO    | idle, waiting for inicio; last result retained on minimo/indice
// COLETA    | accepting samples, running minimum updated per acceptance
// RESULTADO | result offered on resultado_valido until resultado_aceito

module menor_10bit (
   input  logic [9:0] a,
   input  logic [9:0] b,
   output logic       menor
);
   assign menor = (a < b);
endmodule

module controle_minimo_10bit #(
   parameter int N_AMOSTRAS = 8,
   parameter int IDX_W      = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inicio,
   input  logic             dado_valido,
   input  logic [9:0]       dado,
   output logic             dado_pronto,
   output logic [9:0]       minimo,
   output logic [IDX_W-1:0] indice,
   output logic             resultado_valido,
   input  logic             resultado_aceito,
   output logic             ocupado
);

   typedef enum logic [1:0] {
      OCIOSO    = 2'd0,
      COLETA    = 2'd1,
      RESULTADO = 2'd2
   } estado_t;

   localparam logic [IDX_W:0] ULTIMO = (IDX_W+1)'(N_AMOSTRAS - 1);
   localparam logic [IDX_W:0] UM     = (IDX_W+1)'(1);

   estado_t        estado;
   estado_t        prox_estado;
   logic [IDX_W:0] contador;
   logic           aceita;
   logic           menor;

   menor_10bit u_menor (
      .a     (dado),
      .b     (minimo),
      .menor (menor)
   );

   assign dado_pronto      = (estado == COLETA);
   assign resultado_valido = (estado == RESULTADO);
   assign ocupado          = (estado != OCIOSO);
   assign aceita           = dado_valido & dado_pronto;

   always_comb begin
      prox_estado = estado;
      case (estado)
         OCIOSO: begin
            if (inicio)
               prox_estado = COLETA;
         end
         COLETA: begin
            if (aceita && (contador == ULTIMO))
               prox_estado = RESULTADO;
         end
         RESULTADO: begin
            if (resultado_aceito)
               prox_estado = OCIOSO;
         end
         default: prox_estado = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado   <= OCIOSO;
         contador <= '0;
         minimo   <= '0;
         indice   <= '0;
      end else begin
         estado <= prox_estado;
         if ((estado == OCIOSO) && inicio)
            contador <= '0;
         if (aceita) begin
            contador <= contador + UM;
            // first sample seeds the running minimum; later ones replace it only when strictly smaller
            if ((contador == '0) || menor) begin
               minimo <= dado;
               indice <= contador[IDX_W-1:0];
            end
         end
      end
   end

endmodule
